// File: rtl/spi_command_decoder.sv
// Decodes SPI byte frames into register write/read strobes and a read response.
// Define SPI_CMD_CHECKSUM_EN to require a trailing XOR checksum byte on write frames.

module spi_command_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   output logic        in_ready,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        frame_nss,
   output logic [6:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_write,
   output logic        reg_read,
   input  logic [15:0] reg_rdata,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic [7:0]  out_channel,
   output logic        err_abort,
   output logic        err_timeout,
   output logic        err_checksum
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_HI,
      WR_LO,
`ifdef SPI_CMD_CHECKSUM_EN
      WR_CHK,
`endif
      WR_COMMIT,
      RD_REQ,
      RD_CAP,
      RESP
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_nss_sync;
   logic [CNT_W-1:0] r_idle_cnt;
   logic             r_in_ready;
   logic [6:0]       r_reg_addr;
   logic [15:0]      r_reg_wdata;
   logic             r_reg_write;
   logic             r_reg_read;
   logic             r_out_valid;
   logic [15:0]      r_out_data;
   logic [7:0]       r_out_channel;
   logic             r_err_abort;
   logic             r_err_timeout;

   logic w_accept;
   logic w_nss_high;
   logic w_cnt_expired;
   logic w_in_chk;
   logic w_in_frame;
   logic w_take;
   logic w_abort;
   logic w_timeout;
   logic w_in_ready_nxt;

   assign w_accept      = in_valid & r_in_ready;
   assign w_nss_high    = r_nss_sync[1];
   assign w_cnt_expired = (r_idle_cnt == CNT_LIMIT);

`ifdef SPI_CMD_CHECKSUM_EN
   logic r_err_checksum;
   logic w_chk_err;
   logic w_chk_ok;
   assign w_in_chk     = (r_state == WR_CHK);
   assign w_chk_ok     = (in_data == ({1'b0, r_reg_addr} ^ r_reg_wdata[15:8] ^ r_reg_wdata[7:0]));
   assign err_checksum = r_err_checksum;
`else
   assign w_in_chk     = 1'b0;
   assign err_checksum = 1'b0;
`endif

   assign w_in_frame = (r_state == WR_HI) || (r_state == WR_LO) || w_in_chk;

   // Chip-select synchronizer; resets to deselected
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) r_nss_sync <= 2'b11;
      else             r_nss_sync <= {r_nss_sync[0], frame_nss};
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) r_state <= IDLE;
      else             r_state <= w_state_nxt;
   end

   // Next state; abort beats timeout beats a byte accepted in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_abort     = 1'b0;
      w_timeout   = 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
      w_chk_err   = 1'b0;
`endif
      if (w_in_frame) begin
         if (w_nss_high) begin
            w_abort     = 1'b1;
            w_state_nxt = IDLE;
         end else if (w_cnt_expired) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
         end else if (w_accept) begin
            w_take = 1'b1;
            case (r_state)
               WR_HI: w_state_nxt = WR_LO;
`ifdef SPI_CMD_CHECKSUM_EN
               WR_LO: w_state_nxt = WR_CHK;
               WR_CHK: begin
                  if (w_chk_ok) begin
                     w_state_nxt = WR_COMMIT;
                  end else begin
                     w_state_nxt = IDLE;
                     w_chk_err   = 1'b1;
                  end
               end
`else
               WR_LO: w_state_nxt = WR_COMMIT;
`endif
               default: w_state_nxt = IDLE;
            endcase
         end
      end else begin
         case (r_state)
            IDLE:      if (w_accept) w_state_nxt = in_data[7] ? RD_REQ : WR_HI;
            WR_COMMIT: w_state_nxt = IDLE;
            RD_REQ:    w_state_nxt = RD_CAP;
            RD_CAP:    w_state_nxt = RESP;
            RESP:      if (out_ready) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
         endcase
      end
      w_in_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == WR_HI) || (w_state_nxt == WR_LO)
`ifdef SPI_CMD_CHECKSUM_EN
                       || (w_state_nxt == WR_CHK)
`endif
                       ;
   end

   // Mid-frame idle counter; saturates at the limit
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset)                                r_idle_cnt <= '0;
      else if (w_accept)                              r_idle_cnt <= '0;
      else if (w_in_frame && (r_idle_cnt != CNT_LIMIT)) r_idle_cnt <= r_idle_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_reg_addr    <= '0;
         r_reg_wdata   <= '0;
         r_out_data    <= '0;
         r_out_channel <= '0;
      end else begin
         if ((r_state == IDLE) && w_accept)  r_reg_addr         <= in_data[6:0];
         if ((r_state == WR_HI) && w_take)   r_reg_wdata[15:8]  <= in_data;
         if ((r_state == WR_LO) && w_take)   r_reg_wdata[7:0]   <= in_data;
         if (r_state == RD_CAP) begin
            r_out_data    <= reg_rdata;
            r_out_channel <= {1'b0, r_reg_addr};
         end
      end
   end

   // Strobes and handshakes registered from the next state
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_in_ready    <= 1'b0;
         r_reg_write   <= 1'b0;
         r_reg_read    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_err_abort   <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_in_ready    <= w_in_ready_nxt;
         r_reg_write   <= (w_state_nxt == WR_COMMIT);
         r_reg_read    <= (w_state_nxt == RD_REQ);
         r_out_valid   <= (w_state_nxt == RESP);
         r_err_abort   <= w_abort;
         r_err_timeout <= w_timeout;
      end
   end

`ifdef SPI_CMD_CHECKSUM_EN
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) r_err_checksum <= 1'b0;
      else             r_err_checksum <= w_chk_err;
   end
`endif

   assign in_ready    = r_in_ready;
   assign reg_addr    = r_reg_addr;
   assign reg_wdata   = r_reg_wdata;
   assign reg_write   = r_reg_write;
   assign reg_read    = r_reg_read;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_channel = r_out_channel;
   assign err_abort   = r_err_abort;
   assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_spi_command_decoder.sv
// Randomized bench for spi_command_decoder: frames are scored against a register-map
// model with expected strobe/error counts and latencies.

module tb_spi_command_decoder;

   localparam int unsigned T_CYC = 1024;
`ifdef SPI_CMD_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic        clk_clk = 1'b0;
   logic        reset_reset = 1'b1;
   logic        in_ready;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        frame_nss = 1'b0;
   logic [6:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_write;
   logic        reg_read;
   logic [15:0] reg_rdata = 16'h0000;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] out_data;
   logic [7:0]  out_channel;
   logic        err_abort;
   logic        err_timeout;
   logic        err_checksum;

   spi_command_decoder #(.TIMEOUT_CYCLES(T_CYC)) dut (
      .clk_clk      (clk_clk),
      .reset_reset  (reset_reset),
      .in_ready     (in_ready),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .frame_nss    (frame_nss),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_write    (reg_write),
      .reg_read     (reg_read),
      .reg_rdata    (reg_rdata),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_channel  (out_channel),
      .err_abort    (err_abort),
      .err_timeout  (err_timeout),
      .err_checksum (err_checksum)
   );

   always #5 clk_clk = ~clk_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_wr = 0, n_rd = 0, n_ab = 0, n_to = 0, n_ck = 0;
   int s_wr, s_rd, s_ab, s_to, s_ck;
   logic [6:0]  last_wr_addr;
   logic [15:0] last_wr_data;
   int          last_wr_cyc = -1;
   int          last_to_cyc = -1;
   logic [15:0] model_mem [128];
   logic [15:0] mem_dut   [128];

   initial forever begin
      @(posedge clk_clk);
      cyc = cyc + 1;
   end

   // Observe strobes just after each rising edge
   initial forever begin
      @(posedge clk_clk);
      #1;
      if (reg_write === 1'b1) begin
         n_wr++;
         last_wr_addr = reg_addr;
         last_wr_data = reg_wdata;
         last_wr_cyc  = cyc;
         mem_dut[reg_addr] = reg_wdata;
      end
      if (reg_read === 1'b1)     n_rd++;
      if (err_abort === 1'b1)    n_ab++;
      if (err_timeout === 1'b1) begin
         n_to++;
         last_to_cyc = cyc;
      end
      if (err_checksum === 1'b1) n_ck++;
   end

   // Register file: read data valid the cycle after reg_read, noise otherwise
   initial forever begin
      @(posedge clk_clk);
      reg_rdata <= (reg_read === 1'b1) ? mem_dut[reg_addr] : 16'($urandom);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected $finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      s_wr = n_wr; s_rd = n_rd; s_ab = n_ab; s_to = n_to; s_ck = n_ck;
   endtask

   task automatic check_deltas(input string tag, input int dwr, input int drd,
                               input int dab, input int dto, input int dck);
      check({tag, "_wr"},   32'(n_wr - s_wr), 32'(dwr));
      check({tag, "_rd"},   32'(n_rd - s_rd), 32'(drd));
      check({tag, "_abrt"}, 32'(n_ab - s_ab), 32'(dab));
      check({tag, "_tout"}, 32'(n_to - s_to), 32'(dto));
      check({tag, "_csum"}, 32'(n_ck - s_ck), 32'(dck));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"},  {in_ready, out_valid, reg_write, reg_read, err_abort, err_timeout, err_checksum}, 0);
      check({tag, "_reg"},  {reg_addr, reg_wdata}, 0);
      check({tag, "_resp"}, {out_data, out_channel}, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic gap(input int g);
      if (g < 0) idle($urandom_range(0, 3));
      else       idle(g);
   endtask

   // Presents one byte from a falling edge; acc = cycle index of the handshake
   task automatic send_byte(input logic [7:0] b, output int acc);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk_clk);
         n++;
      end
      if (n >= 50) check("in_ready_wait", 32'(in_ready), 1);
      acc = cyc;
      @(negedge clk_clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic write_frame(input logic [6:0] addr, input logic [15:0] data,
                              input bit bad_chk, input int g, input string tag);
      int acc;
      bit exp_ck_err;
      logic [7:0] ck;
      exp_ck_err = CHK_ON && bad_chk;
      snap();
      send_byte({1'b0, addr}, acc);
      gap(g);
      send_byte(data[15:8], acc);
      gap(g);
      send_byte(data[7:0], acc);
`ifdef SPI_CMD_CHECKSUM_EN
      ck = {1'b0, addr} ^ data[15:8] ^ data[7:0];
      if (bad_chk) ck = ck ^ 8'($urandom_range(1, 255));
      gap(g);
      send_byte(ck, acc);
`else
      ck = 8'h00;
`endif
      idle(3);
      if (exp_ck_err) begin
         check_deltas(tag, 0, 0, 0, 0, 1);
      end else begin
         check_deltas(tag, 1, 0, 0, 0, 0);
         check({tag, "_addr"}, last_wr_addr, addr);
         check({tag, "_data"}, last_wr_data, data);
         check({tag, "_lat"},  32'(last_wr_cyc), 32'(acc + 1));
         model_mem[addr] = data;
      end
   endtask

   task automatic read_frame(input logic [6:0] addr, input int stall, input bit nss_glitch,
                             input string tag);
      int acc;
      int n;
      snap();
      send_byte({1'b1, addr}, acc);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk_clk);
         n++;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"},  out_data, model_mem[addr]);
      check({tag, "_chan"},  out_channel, {1'b0, addr});
      if (nss_glitch) frame_nss = 1'b1;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk_clk);
         check({tag, "_hold"}, {out_valid, in_ready, out_data, out_channel},
               {1'b1, 1'b0, model_mem[addr], 1'b0, addr});
      end
      out_ready = 1'b1;
      @(negedge clk_clk);
      out_ready = 1'b0;
      check({tag, "_done"}, {out_valid, in_ready}, 2'b01);
      frame_nss = 1'b0;
      idle(3);
      check_deltas(tag, 0, 1, 0, 0, 0);
   endtask

   initial begin
      int acc;
      int n;
      int kind;
      logic [6:0]  a;
      logic [15:0] d;

      for (int i = 0; i < 128; i++) begin
         d = 16'($urandom);
         model_mem[i] = d;
         mem_dut[i]   = d;
      end

      idle(3);
      check_reset_outputs("rst_init");
      reset_reset = 1'b0;
      @(posedge clk_clk);
      #1;
      check("rst_init_ready", in_ready, 1);
      @(negedge clk_clk);
      idle(3);

      write_frame(7'h05, 16'h1234, 1'b0, -1, "wr_basic");

      model_mem[5] = 16'hBEEF;
      mem_dut[5]   = 16'hBEEF;
      read_frame(7'h05, 10, 1'b0, "rd_basic");

      // Abort coinciding with an accepted low byte: byte must be dropped
      snap();
      send_byte(8'h05, acc);
      send_byte(8'h12, acc);
      frame_nss = 1'b1;
      idle(2);
      in_valid = 1'b1;
      in_data  = 8'h77;
      @(negedge clk_clk);
      in_valid = 1'b0;
      idle(3);
      check_deltas("abort", 0, 0, 1, 0, 0);
      check("abort_lo_kept", reg_wdata, 16'h1234);
      frame_nss = 1'b0;
      idle(3);
      write_frame(7'h05, 16'h5AC3, 1'b0, -1, "after_abort");

      snap();
      frame_nss = 1'b1;
      idle(6);
      frame_nss = 1'b0;
      idle(3);
      check_deltas("nss_idle", 0, 0, 0, 0, 0);
      check("nss_idle_ready", in_ready, 1);

      snap();
      send_byte(8'h05, acc);
      n = 0;
      while (n_to == s_to && n < int'(T_CYC) + 50) begin
         @(negedge clk_clk);
         n++;
      end
      idle(5);
      check_deltas("timeout", 0, 0, 0, 1, 0);
      check("timeout_lat", 32'(last_to_cyc), 32'(acc + 1 + int'(T_CYC)));
      check("timeout_idle_ready", in_ready, 1);

      write_frame(7'h06, 16'hABCD, 1'b0, int'(T_CYC) - 30, "slow_wr");

`ifdef SPI_CMD_CHECKSUM_EN
      snap();
      send_byte(8'h05, acc);
      send_byte(8'h12, acc);
      send_byte(8'h34, acc);
      send_byte(8'h00, acc);
      idle(3);
      check_deltas("csum_bad", 0, 0, 0, 0, 1);
`endif

      snap();
      send_byte(8'h40, acc);
      send_byte(8'h99, acc);
      reset_reset = 1'b1;
      @(negedge clk_clk);
      check_reset_outputs("rst_wr");
      reset_reset = 1'b0;
      @(posedge clk_clk);
      #1;
      check("rst_wr_ready", in_ready, 1);
      @(negedge clk_clk);
      idle(3);
      check_deltas("rst_wr", 0, 0, 0, 0, 0);

      snap();
      send_byte({1'b1, 7'h11}, acc);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk_clk);
         n++;
      end
      check("rst_rd_valid", out_valid, 1);
      reset_reset = 1'b1;
      @(negedge clk_clk);
      check_reset_outputs("rst_rd");
      reset_reset = 1'b0;
      @(posedge clk_clk);
      #1;
      check("rst_rd_ready", in_ready, 1);
      @(negedge clk_clk);
      idle(3);
      check_deltas("rst_rd", 0, 1, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         a    = 7'($urandom);
         d    = 16'($urandom);
         case (kind)
            0:       write_frame(a, d, 1'b0, -1, "rnd_wr");
            1:       read_frame(a, $urandom_range(0, 4), 1'($urandom_range(0, 1)), "rnd_rd");
            default: write_frame(a, d, 1'b1, -1, "rnd_wrbad");
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_command_decoder.md
SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: mid-frame idle limit in clk_clk cycles; legal range 2..65535.
REQ-002 clk_clk  in  1  single clock; all logic on its rising edge.
REQ-003 reset_reset  in  1  reset, asynchronous, active-high.
REQ-004 in_ready  out  1  Avalon-ST ready toward the SPI slave byte source.
REQ-005 in_valid  in  1  byte valid from the SPI slave.
REQ-006 in_data  in  8  received byte.
REQ-007 frame_nss  in  1  raw SPI chip-select, active-low, asynchronous to clk_clk.
REQ-008 reg_addr  out  7  register address.
REQ-009 reg_wdata  out  16  write data.
REQ-010 reg_write  out  1  one-cycle write strobe.
REQ-011 reg_read  out  1  one-cycle read strobe.
REQ-012 reg_rdata  in  16  read data, valid exactly 1 cycle after reg_read.
REQ-013 out_ready  in  1  ready from the SPI slave response sink.
REQ-014 out_valid  out  1  response valid.
REQ-015 out_data  out  16  response word.
REQ-016 out_channel  out  8  response channel, {1'b0, reg_addr}.
REQ-017 err_abort, err_timeout, err_checksum  out  1 each  one-cycle error pulses.

Function
REQ-018 The block SHALL pass frame_nss through a 2-FF synchronizer; "nss_high" below means the synchronized value is 1.
REQ-019 States SHALL be: IDLE, WR_HI, WR_LO, WR_CHK, WR_COMMIT, RD_REQ, RD_CAP, RESP.
REQ-020 A byte SHALL be accepted only on a cycle with in_valid and in_ready both 1.
REQ-021 in_ready SHALL be 1 in IDLE, WR_HI, WR_LO and WR_CHK, and 0 in all other states.
REQ-022 In IDLE, an accepted byte is the header: bit7=1 means read, bit7=0 means write; bits6:0 SHALL be latched into reg_addr.
REQ-023 Transitions from IDLE: a write header goes to WR_HI; a read header goes to RD_REQ.
REQ-024 WR_HI SHALL latch the byte into reg_wdata[15:8] and go to WR_LO; WR_LO SHALL latch reg_wdata[7:0].
REQ-025 reg_write SHALL be 1 only in WR_COMMIT, lasting exactly one cycle, then the FSM returns to IDLE.
REQ-026 Write latency: reg_write SHALL assert 1 cycle after the last frame byte is accepted.
REQ-027 RD_REQ SHALL assert reg_read for one cycle, then go to RD_CAP.
REQ-028 RD_CAP SHALL register reg_rdata into out_data, then go to RESP.
REQ-029 In RESP, out_valid=1 and out_data/out_channel SHALL hold stable until out_ready=1, then the FSM returns to IDLE.
REQ-030 In RESP, nss_high and the timeout SHALL be ignored; the response is never dropped.
REQ-031 If nss_high in WR_HI/WR_LO/WR_CHK: go to IDLE, no reg_write, pulse err_abort; abort wins over a byte accepted the same cycle, and that byte is discarded.
REQ-032 nss_high in IDLE SHALL have no effect.
REQ-033 A 16-bit idle counter SHALL clear on each accepted byte and on entering WR_HI.
REQ-034 It SHALL count while in WR_HI/WR_LO/WR_CHK with no byte accepted.
REQ-035 On reaching TIMEOUT_CYCLES-1: go to IDLE, no reg_write, pulse err_timeout; the counter SHALL NOT wrap.
REQ-036 If abort and timeout coincide, only err_abort SHALL pulse.

Reset
REQ-037 While reset_reset=1: state IDLE, and in_ready, out_valid, reg_write, reg_read and all err_* are 0.
REQ-038 While reset_reset=1: reg_addr, reg_wdata, out_data, out_channel and the counter are 0; the synchronizer resets to 1 (deselected).
REQ-039 Reset asserted mid-frame or mid-response SHALL discard the frame with no strobe; in_ready SHALL assert the first cycle after release.

Configuration
REQ-040 Macro SPI_CMD_CHECKSUM_EN defined: after WR_LO the FSM goes to WR_CHK.
REQ-041 In WR_CHK, the accepted byte SHALL equal header XOR hi XOR lo. On a match go to WR_COMMIT; otherwise go to IDLE with no reg_write and pulse err_checksum. Reads carry no checksum.
REQ-042 Macro undefined: WR_LO goes directly to WR_COMMIT; WR_CHK does not exist; err_checksum is tied to 0.

Verification
REQ-043 Write 0x05, 0x12, 0x34 (+0x23 if checksum enabled) -> one reg_write with addr=0x05 and wdata=0x1234, 1 cycle after the last byte.
REQ-044 Read 0x85 with reg_rdata=0xBEEF -> reg_read one cycle; out_valid with data=0xBEEF and channel=0x05; out_ready held 0 for 10 cycles -> data stable and in_ready=0.
REQ-045 Write 0x05, 0x12, then frame_nss high -> err_abort pulse, no reg_write; next header decoded normally.
REQ-046 Write 0x05 then no bytes for 1024 cycles -> err_timeout exactly once, IDLE, no reg_write.
REQ-047 Checksum enabled: 0x05, 0x12, 0x34, 0x00 -> err_checksum, no reg_write.
REQ-048 Reset pulsed mid-read and mid-write -> all outputs at reset values, no strobes; in_ready=1 the cycle after release.
